// File: rtl/emulador_controle_pkg.sv
// Shared constants for the gamepad link: button bit positions, phase encoding and timeout sizing.
package pkg_controle;

    localparam int BT_UP    = 0;
    localparam int BT_DOWN  = 1;
    localparam int BT_LEFT  = 2;
    localparam int BT_RIGHT = 3;
    localparam int BT_A     = 4;
    localparam int BT_B     = 5;
    localparam int BT_C     = 6;
    localparam int BT_START = 7;
    localparam int BT_X     = 8;
    localparam int BT_Y     = 9;
    localparam int BT_Z     = 10;
    localparam int BT_MODE  = 11;

    typedef enum logic [2:0] {
        FASE_0, FASE_1, FASE_2, FASE_3, FASE_4, FASE_5, FASE_6, FASE_7
    } fase_t;

    localparam int TIMEOUT_PADRAO = 75000;

    function automatic int largura_contador(input int valor);
        return $clog2(valor + 1);
    endfunction

endpackage

// File: rtl/emulador_controle_if.sv
// Pin-level link between a Sega-style host (drives Select) and the pad (drives data pins).
interface emulador_controle_if;

    logic        Select;
    logic [11:0] Botoes;
    logic        Pino1;
    logic        Pino2;
    logic        Pino3;
    logic        Pino4;
    logic        Pino6;
    logic        Pino9;
    logic [2:0]  Fase;

    modport master (
        output Select, Botoes,
        input  Pino1, Pino2, Pino3, Pino4, Pino6, Pino9, Fase
    );

    modport slave (
        input  Select, Botoes,
        output Pino1, Pino2, Pino3, Pino4, Pino6, Pino9, Fase
    );

endinterface

// File: rtl/emulador_controle_sincronizador_borda.sv
// 2-FF synchroniser for an asynchronous level plus edge flags on the synchronised value.
// Latency: 2 cycles to sync, edge flags one cycle wide; never stalls.
module sincronizador_borda #(
    parameter logic INICIAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic meta;
    logic estavel;
    logic atrasado;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= INICIAL;
            estavel  <= INICIAL;
            atrasado <= INICIAL;
        end else begin
            meta     <= din;
            estavel  <= meta;
            atrasado <= estavel;
        end
    end

    assign sync     = estavel;
    assign rise     = estavel & ~atrasado;
    assign fall     = ~estavel & atrasado;
    assign any_edge = estavel ^ atrasado;

endmodule

// File: rtl/emulador_controle.sv
// Six/three-button pad emulator: Select edges step a phase counter that picks which buttons drive the pins.
// Latency: Select edge -> pins 4 cycles, Botoes -> pins 1 cycle; no backpressure, never stalls.
module emulador_controle
    import pkg_controle::*;
#(
    parameter int TIMEOUT = TIMEOUT_PADRAO,
    parameter bit MODO6   = 1'b1
) (
    input  logic          Clock50,
    input  logic          Reset,
    emulador_controle_if.slave bus
);

    localparam int            CW        = largura_contador(TIMEOUT);
    localparam logic [CW-1:0] LIMITE    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMITE_M1 = CW'(TIMEOUT - 1);

    logic          sel_sync;
    logic          sel_rise;
    logic          sel_fall;
    logic          sel_any;
    fase_t         fase;
    fase_t         fase_next;
    fase_t         fase_dec;
    fase_t         fase_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [5:0]    pinos;
    logic [5:0]    pinos_next;

    sincronizador_borda #(.INICIAL(1'b1)) u_sinc (
        .clk      (Clock50),
        .rst      (Reset),
        .din      (bus.Select),
        .sync     (sel_sync),
        .rise     (sel_rise),
        .fall     (sel_fall),
        .any_edge (sel_any)
    );

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            fase   <= FASE_0;
            cnt    <= '0;
            pinos  <= '1;
            fase_q <= FASE_0;
        end else begin
            fase   <= fase_next;
            cnt    <= cnt_next;
            pinos  <= pinos_next;
            fase_q <= fase;
        end
    end

    // An edge always beats the timeout; once saturated, resync re-applies harmlessly every cycle.
    always_comb begin
        fase_next = fase;
        cnt_next  = cnt;
        if (sel_rise || sel_fall) begin
            fase_next = fase_t'(fase + 3'd1);
        end else if (cnt >= LIMITE_M1) begin
            fase_next = sel_sync ? FASE_0 : FASE_1;
        end
        if (sel_any) begin
            cnt_next = '0;
        end else if (cnt != LIMITE) begin
            cnt_next = cnt + CW'(1);
        end
    end

    // Pin vector order: {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}; pressed button drives 0.
    always_comb begin
        fase_dec   = (!MODO6 && fase[2]) ? fase_t'({1'b0, fase[1:0]}) : fase;
        pinos_next = ~{bus.Botoes[BT_C], bus.Botoes[BT_B], bus.Botoes[BT_RIGHT],
                       bus.Botoes[BT_LEFT], bus.Botoes[BT_DOWN], bus.Botoes[BT_UP]};
        case (fase_dec)
            FASE_1, FASE_3: pinos_next = {~bus.Botoes[BT_START], ~bus.Botoes[BT_A], 2'b00,
                                          ~bus.Botoes[BT_DOWN], ~bus.Botoes[BT_UP]};
            FASE_5:         pinos_next = {~bus.Botoes[BT_START], ~bus.Botoes[BT_A], 4'b0000};
            FASE_6:         pinos_next = ~{bus.Botoes[BT_C], bus.Botoes[BT_B], bus.Botoes[BT_MODE],
                                           bus.Botoes[BT_X], bus.Botoes[BT_Y], bus.Botoes[BT_Z]};
            FASE_7:         pinos_next = {~bus.Botoes[BT_START], ~bus.Botoes[BT_A], 4'b1111};
            default:        ;
        endcase
    end

    assign bus.Pino1 = pinos[0];
    assign bus.Pino2 = pinos[1];
    assign bus.Pino3 = pinos[2];
    assign bus.Pino4 = pinos[3];
    assign bus.Pino6 = pinos[4];
    assign bus.Pino9 = pinos[5];
    assign bus.Fase  = fase_q;

endmodule
